// File: rtl/int_to_float_pkg.sv
// Shared floating-point constants and the converter state encoding, reused by
// the divider, multiplier and float_to_int blocks.
package int_to_float_pkg;

  localparam int FP_WIDTH   = 32;
  localparam int MANT_WIDTH = 23;
  localparam logic [7:0] EXP_BIAS = 8'd127;

  typedef enum logic [3:0] {
    ST_GET_A     = 4'd0,
    ST_CONVERT_0 = 4'd1,
    ST_CONVERT_1 = 4'd2,
    ST_CONVERT_2 = 4'd3,
    ST_ROUND     = 4'd4,
    ST_PACK      = 4'd5,
    ST_PUT_Z     = 4'd6
  } state_t;

endpackage

// File: rtl/int_to_float.sv
// 32-bit integer to IEEE-754 single converter with round-to-nearest-even.
// Normalises one bit per clock; stb/ack handshakes on both sides.
module int_to_float
  import int_to_float_pkg::*;
#(
  parameter bit SIGNED = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [FP_WIDTH-1:0] input_a,
  input  logic                input_a_stb,
  output logic                input_a_ack,
  output logic [FP_WIDTH-1:0] output_z,
  output logic                output_z_stb,
  input  logic                output_z_ack
);

  state_t              r_state;
  logic [FP_WIDTH-1:0] r_a;
  logic [FP_WIDTH-1:0] r_value;
  logic [FP_WIDTH-1:0] r_z;
  logic [FP_WIDTH-1:0] r_output_z;
  logic [7:0]          r_z_e;
  logic [23:0]         r_z_m;
  logic                r_z_s;
  logic                r_guard;
  logic                r_round_bit;
  logic                r_sticky;
  logic                r_ack;
  logic                r_stb;

  logic                w_sign;

  assign w_sign       = SIGNED && r_a[FP_WIDTH-1];
  assign input_a_ack  = r_ack;
  assign output_z_stb = r_stb;
  assign output_z     = r_output_z;

  // NOTE: every register here is state, so the whole block uses non-blocking
  // assignments; mixing in blocking ones would make the next-state depend on
  // statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the datapath is reset as well as the control, because output_z
      // must read 0 during reset; internal datapath regs follow for symmetry.
      r_state     <= ST_GET_A;
      r_a         <= '0;
      r_value     <= '0;
      r_z         <= '0;
      r_output_z  <= '0;
      r_z_e       <= '0;
      r_z_m       <= '0;
      r_z_s       <= 1'b0;
      r_guard     <= 1'b0;
      r_round_bit <= 1'b0;
      r_sticky    <= 1'b0;
      r_ack       <= 1'b0;
      r_stb       <= 1'b0;
    end else begin
      case (r_state)
        ST_GET_A: begin
          r_ack <= 1'b1;
          if (r_ack && input_a_stb) begin
            r_a     <= input_a;
            r_ack   <= 1'b0;
            r_state <= ST_CONVERT_0;
          end
        end

        ST_CONVERT_0: begin
          if (r_a == '0) begin
            r_z     <= '0;
            r_state <= ST_PUT_Z;
          end else begin
            // -2^31 negates to itself, which read unsigned is the magnitude.
            r_z_s   <= w_sign;
            r_value <= w_sign ? -r_a : r_a;
            r_z_e   <= 8'd31;
            r_state <= ST_CONVERT_1;
          end
        end

        ST_CONVERT_1: begin
          if (!r_value[FP_WIDTH-1]) begin
            r_value <= r_value << 1;
            r_z_e   <= r_z_e - 8'd1;
          end else begin
            r_state <= ST_CONVERT_2;
          end
        end

        ST_CONVERT_2: begin
          r_z_m       <= r_value[31:8];
          r_guard     <= r_value[7];
          r_round_bit <= r_value[6];
          r_sticky    <= |r_value[5:0];
          r_state     <= ST_ROUND;
        end

        ST_ROUND: begin
          if (r_guard && (r_round_bit || r_sticky || r_z_m[0])) begin
            r_z_m <= r_z_m + 24'd1;
            if (r_z_m == 24'hffffff) r_z_e <= r_z_e + 8'd1;
          end
          r_state <= ST_PACK;
        end

        ST_PACK: begin
          // A wrapped mantissa leaves the stored fraction at zero, which is
          // exactly right once the exponent has been bumped.
          r_z     <= {r_z_s, r_z_e + EXP_BIAS, r_z_m[MANT_WIDTH-1:0]};
          r_state <= ST_PUT_Z;
        end

        ST_PUT_Z: begin
          r_output_z <= r_z;
          r_stb      <= 1'b1;
          if (r_stb && output_z_ack) begin
            r_stb   <= 1'b0;
            r_state <= ST_GET_A;
          end
        end

        default: r_state <= ST_GET_A;
      endcase
    end
  end

endmodule

// File: tb/tb_int_to_float.sv
// Directed bench for int_to_float: a signed and an unsigned instance checked
// against an arithmetic reference model for value, latency and handshaking.
module tb_int_to_float;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_a [2];
  logic        in_stb [2];
  logic        in_ack [2];
  logic [31:0] z [2];
  logic        z_stb [2];
  logic        z_ack [2];

  logic [31:0] exp_val [2];
  bit          busy [2];
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  int_to_float #(.SIGNED(1'b1)) u_signed (
    .clk(clk), .rst(rst),
    .input_a(in_a[0]), .input_a_stb(in_stb[0]), .input_a_ack(in_ack[0]),
    .output_z(z[0]), .output_z_stb(z_stb[0]), .output_z_ack(z_ack[0])
  );

  int_to_float #(.SIGNED(1'b0)) u_unsigned (
    .clk(clk), .rst(rst),
    .input_a(in_a[1]), .input_a_stb(in_stb[1]), .input_a_ack(in_ack[1]),
    .output_z(z[1]), .output_z_stb(z_stb[1]), .output_z_ack(z_ack[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: exact magnitude, locate the leading one, round the discarded
  // bits to nearest-even by comparing the remainder against half an ulp.
  function automatic logic [31:0] model(input logic [31:0] v, input bit sgn);
    bit s;
    longint unsigned mag, m, rem, half;
    int e, shift;
    logic [7:0] be;
    s   = sgn && v[31];
    mag = s ? (64'h1_0000_0000 - {32'd0, v}) : {32'd0, v};
    if (mag == 0) return 32'd0;
    e = 0;
    for (int i = 0; i < 33; i++) if ((mag >> i) != 0) e = i;
    if (e <= 23) begin
      m = mag << (23 - e);
    end else begin
      shift = e - 23;
      m     = mag >> shift;
      rem   = mag & ((64'd1 << shift) - 1);
      half  = 64'd1 << (shift - 1);
      if (rem > half || (rem == half && m[0])) m = m + 1;
      if (m == (64'd1 << 24)) begin
        m = m >> 1;
        e = e + 1;
      end
    end
    be = 8'(e + 127);
    return {s, be, m[22:0]};
  endfunction

  function automatic int model_lat(input logic [31:0] v, input bit sgn);
    longint unsigned mag;
    int e;
    mag = (sgn && v[31]) ? (64'h1_0000_0000 - {32'd0, v}) : {32'd0, v};
    if (mag == 0) return 2;
    e = 0;
    for (int i = 0; i < 33; i++) if ((mag >> i) != 0) e = i;
    return 6 + (31 - e);
  endfunction

  // Every cycle a result is presented it must be the expected, stable value.
  always @(negedge clk) begin
    if (!rst) begin
      for (int d = 0; d < 2; d++) begin
        if (z_stb[d]) begin
          check("stb_only_when_busy", {31'd0, busy[d]}, 32'd1);
          check("output_z", z[d], exp_val[d]);
          check("in_ack_low_while_stb", {31'd0, in_ack[d]}, 32'd0);
        end
      end
    end
  end

  task automatic accept(input int d, input logic [31:0] val);
    int n;
    in_a[d]   = val;
    in_stb[d] = 1'b1;
    n = 0;
    while (!in_ack[d] && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("accept_wait_le1", {31'd0, (n <= 1)}, 32'd1);
    if (in_ack[d]) begin
      exp_val[d] = model(val, (d == 0));
      busy[d]    = 1'b1;
      @(posedge clk);
      #1;
    end
    in_stb[d] = 1'b0;
  endtask

  task automatic run(input int d, input logic [31:0] val, input logic [31:0] lit, input int hold);
    int lat;
    check("model_vs_literal", model(val, (d == 0)), lit);
    accept(d, val);
    lat = 0;
    while (!z_stb[d] && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", lat, model_lat(val, (d == 0)));
    z_ack[d] = 1'b0;
    repeat (hold) @(posedge clk);
    #1;
    z_ack[d] = 1'b1;
    @(posedge clk);
    #1;
    z_ack[d] = 1'b0;
    busy[d]  = 1'b0;
    check("stb_drops_after_ack", {31'd0, z_stb[d]}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      in_a[d] = '0; in_stb[d] = 1'b0; z_ack[d] = 1'b0;
      exp_val[d] = '0; busy[d] = 1'b0;
    end

    // Model pins for the latency boundaries.
    check("model_lat_one", model_lat(32'h1, 1'b1), 32'd37);
    check("model_lat_zero", model_lat(32'h0, 1'b1), 32'd2);
    check("model_lat_min", model_lat(32'h8000_0000, 1'b1), 32'd6);

    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      check("rst_in_ack", {31'd0, in_ack[d]}, 32'd0);
      check("rst_z_stb", {31'd0, z_stb[d]}, 32'd0);
      check("rst_z", z[d], 32'd0);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("ack_after_rst_s", {31'd0, in_ack[0]}, 32'd1);
    check("ack_after_rst_u", {31'd0, in_ack[1]}, 32'd1);

    run(0, 32'h0000_0001, 32'h3F80_0000, 0);
    run(0, 32'hFFFF_FFFF, 32'hBF80_0000, 0);
    run(0, 32'h0000_0000, 32'h0000_0000, 0);
    run(0, 32'h8000_0000, 32'hCF00_0000, 0);
    run(0, 32'h0100_0001, 32'h4B80_0000, 0);
    run(0, 32'h0100_0003, 32'h4B80_0002, 0);
    run(0, 32'h7FFF_FFFF, 32'h4F00_0000, 0);
    run(1, 32'hFFFF_FFFF, 32'h4F80_0000, 0);
    run(1, 32'h8000_0000, 32'h4F00_0000, 0);
    run(1, 32'h0000_0003, 32'h4040_0000, 0);
    // Back-pressure, then an immediate follow-on word.
    run(0, 32'hFFFF_FC18, 32'hC47A_0000, 10);
    run(0, 32'h0000_0005, 32'h40A0_0000, 0);

    // Reset while normalising: abandon, no stale result.
    accept(0, 32'h0000_0001);
    repeat (5) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    busy[0] = 1'b0;
    check("midrst_in_ack", {31'd0, in_ack[0]}, 32'd0);
    check("midrst_z_stb", {31'd0, z_stb[0]}, 32'd0);
    check("midrst_z", z[0], 32'd0);
    check("midrst_z_u", z[1], 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_ack", {31'd0, in_ack[0]}, 32'd1);
    check("post_rst_stb", {31'd0, z_stb[0]}, 32'd0);
    repeat (45) @(posedge clk);
    #1;
    check("no_stale_stb", {31'd0, z_stb[0]}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
